// File: rtl/sar_control_prog.sv
// Programmable nonbinary SAR controller: sequences a run-time loaded weight table
// through the capacitor matrix, with optional LSB vote averaging and a valid/ready result port.
module sar_control_prog #(
  parameter int RESULT_BITS  = 12,
  parameter int MAX_STEPS    = 16,
  parameter int STEP_W       = 5,
  parameter int AVG_MAX_LOG2 = 4,
  parameter int AVG_REGION   = 4,
  localparam int AW          = $clog2(MAX_STEPS),
  localparam int CW          = AVG_MAX_LOG2 + 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic                   continuous,
  input  logic [STEP_W-1:0]      num_steps,
  input  logic [2:0]             avg_log2,
  input  logic                   cfg_we,
  input  logic [AW-1:0]          cfg_addr,
  input  logic [RESULT_BITS-1:0] cfg_wdata,
  input  logic                   comparator_in,
  output logic                   sample,
  output logic                   nsample,
  output logic                   enable,
  output logic                   busy,
  output logic [RESULT_BITS-1:0] p_switch,
  output logic [RESULT_BITS-1:0] n_switch,
  output logic [RESULT_BITS-1:0] result,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   overrun
);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONVERT, DONE} state_t;

  function automatic logic [RESULT_BITS-1:0] sat_add(input logic [RESULT_BITS-1:0] a,
                                                     input logic [RESULT_BITS-1:0] b);
    logic [RESULT_BITS:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[RESULT_BITS] ? {RESULT_BITS{1'b1}} : s[RESULT_BITS-1:0];
  endfunction

  function automatic logic [RESULT_BITS-1:0] binary_weight(input int i);
    if (i < RESULT_BITS) begin
      return {{(RESULT_BITS-1){1'b0}}, 1'b1} << (RESULT_BITS - 1 - i);
    end else begin
      return '0;
    end
  endfunction

  state_t                 state_q, state_d;
  logic [RESULT_BITS-1:0] data_q, data_d;
  logic [STEP_W-1:0]      idx_q, idx_d;
  logic [STEP_W-1:0]      ns_q, ns_d;
  logic [2:0]             al_q, al_d;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic [CW-1:0]          sum_q, sum_d;
  logic [RESULT_BITS-1:0] result_q, result_d;
  logic                   result_valid_q, result_valid_d;
  logic                   overrun_q, overrun_d;
  logic                   sample_q, sample_d;
  logic                   nsample_q, nsample_d;
  logic                   enable_q, enable_d;
  logic                   busy_q, busy_d;
  logic [RESULT_BITS-1:0] n_switch_q, n_switch_d;
  logic [RESULT_BITS-1:0] p_switch_q, p_switch_d;
  logic [RESULT_BITS-1:0] w_q [MAX_STEPS];
  logic [RESULT_BITS-1:0] w_d [MAX_STEPS];

  logic [RESULT_BITS-1:0] trial_s;
  logic                   avg_step_s;
  logic                   last_cycle_s;
  logic [CW-1:0]          sum_now_s;
  logic                   decision_s;
  logic                   load_s;
  logic [RESULT_BITS-1:0] load_value_s;

  // Step decision: averaged steps cover the last AVG_REGION steps (all of them for short runs).
  always_comb begin
    trial_s      = sat_add(data_q, w_q[idx_q[AW-1:0]]);
    avg_step_s   = (al_q != 3'd0) && ((int'(idx_q) + AVG_REGION) >= int'(ns_q));
    sum_now_s    = sum_q + CW'(comparator_in);
    last_cycle_s = !avg_step_s || (cnt_q == CW'((32'd1 << al_q) - 32'd1));
    if (avg_step_s) begin
      decision_s = (sum_now_s >= CW'(32'd1 << (al_q - 3'd1)));
    end else begin
      decision_s = comparator_in;
    end
  end

  always_comb begin
    state_d      = state_q;
    data_d       = data_q;
    idx_d        = idx_q;
    ns_d         = ns_q;
    al_d         = al_q;
    cnt_d        = cnt_q;
    sum_d        = sum_q;
    load_s       = 1'b0;
    load_value_s = data_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SAMPLE;
          ns_d    = ((num_steps == '0) || (num_steps > STEP_W'(MAX_STEPS))) ?
                    STEP_W'(MAX_STEPS) : num_steps;
          al_d    = (avg_log2 > 3'(AVG_MAX_LOG2)) ? 3'(AVG_MAX_LOG2) : avg_log2;
          data_d  = '0;
          idx_d   = '0;
          cnt_d   = '0;
          sum_d   = '0;
        end
      end
      SAMPLE: begin
        state_d = CONVERT;
        idx_d   = '0;
        cnt_d   = '0;
        sum_d   = '0;
      end
      CONVERT: begin
        if (last_cycle_s) begin
          cnt_d = '0;
          sum_d = '0;
          if (decision_s) begin
            data_d = trial_s;
          end
          if (idx_q == ns_q - STEP_W'(1)) begin
            state_d      = DONE;
            load_s       = 1'b1;
            load_value_s = decision_s ? trial_s : data_q;
          end else begin
            idx_d = idx_q + STEP_W'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
          sum_d = sum_now_s;
        end
      end
      DONE: begin
        if (continuous) begin
          state_d = SAMPLE;
          data_d  = '0;
          idx_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Result handshake: a load while unread and not being taken flags an overrun.
  always_comb begin
    result_d       = result_q;
    result_valid_d = result_valid_q;
    overrun_d      = 1'b0;
    if (load_s) begin
      result_d       = load_value_s;
      result_valid_d = 1'b1;
      overrun_d      = result_valid_q && !result_ready;
    end else if (result_valid_q && result_ready) begin
      result_valid_d = 1'b0;
    end
  end

  // Outputs are computed from next-state values so the registered copies line up with the state.
  always_comb begin
    sample_d  = (state_d == SAMPLE);
    nsample_d = !sample_d;
    enable_d  = (state_d == CONVERT);
    busy_d    = (state_d != IDLE);
    if (state_d == CONVERT) begin
      n_switch_d = sat_add(data_d, w_q[idx_d[AW-1:0]]);
    end else begin
      n_switch_d = '0;
    end
    p_switch_d = ~n_switch_d;
  end

  always_comb begin
    w_d = w_q;
    if (cfg_we && !busy_q && (int'(cfg_addr) < MAX_STEPS)) begin
      w_d[cfg_addr] = cfg_wdata;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= IDLE;
      data_q         <= '0;
      idx_q          <= '0;
      ns_q           <= STEP_W'(MAX_STEPS);
      al_q           <= 3'd0;
      cnt_q          <= '0;
      sum_q          <= '0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      overrun_q      <= 1'b0;
      sample_q       <= 1'b0;
      nsample_q      <= 1'b1;
      enable_q       <= 1'b0;
      busy_q         <= 1'b0;
      n_switch_q     <= '0;
      p_switch_q     <= '1;
      for (int i = 0; i < MAX_STEPS; i++) begin
        w_q[i] <= binary_weight(i);
      end
    end else begin
      state_q        <= state_d;
      data_q         <= data_d;
      idx_q          <= idx_d;
      ns_q           <= ns_d;
      al_q           <= al_d;
      cnt_q          <= cnt_d;
      sum_q          <= sum_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      overrun_q      <= overrun_d;
      sample_q       <= sample_d;
      nsample_q      <= nsample_d;
      enable_q       <= enable_d;
      busy_q         <= busy_d;
      n_switch_q     <= n_switch_d;
      p_switch_q     <= p_switch_d;
      for (int i = 0; i < MAX_STEPS; i++) begin
        w_q[i] <= w_d[i];
      end
    end
  end

  assign sample       = sample_q;
  assign nsample      = nsample_q;
  assign enable       = enable_q;
  assign busy         = busy_q;
  assign n_switch     = n_switch_q;
  assign p_switch     = p_switch_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign overrun      = overrun_q;

endmodule
